// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file write-port arbiter: FSM states,
// grant-source encodings and the MDU result queue entry.
package regfile_arb_pkg;

  // Default widths of the register file write port.
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  // Arbiter FSM: no pending MDU results, results pending, forced drain.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arb_state_t;

  // Which source owns the write port in the current cycle.
  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_WB   = 2'd1;
  localparam logic [1:0] GNT_Q    = 2'd2;

  // One queued MDU result. valid drops when a younger WB write to the
  // same register makes the result stale.
  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] a3;
    logic [RF_DATA_W-1:0] wd;
  } q_entry_t;

endpackage

// File: rtl/regwr_queue.sv
// Circular FIFO of MDU results. Every entry carries its own valid bit so
// a writeback to the same register can cancel it in place; cancelled
// entries still occupy a slot until they reach the head and are popped.
module regwr_queue
  import regfile_arb_pkg::*;
#(
  parameter int QDEPTH     = 2,
  parameter int ADDR_Nbits = RF_ADDR_W,
  parameter int CNT_W      = $clog2(QDEPTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  q_entry_t              i_pushEntry,
  input  logic                  i_pop,
  input  logic                  i_invEn,
  input  logic [ADDR_Nbits-1:0] i_invAddr,
  output q_entry_t              o_head,
  output logic [CNT_W-1:0]      o_count
);

  localparam int PTR_W = $clog2(QDEPTH);

  q_entry_t         r_mem [QDEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_count;

  // Invalidate matching entries, then apply push/pop; a push lands after the
  // invalidate sweep so the fresh entry is never hit by the same-cycle match.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_mem[i].valid <= 1'b0;
      end
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (i_invEn && (r_mem[i].a3 == i_invAddr)) begin
          r_mem[i].valid <= 1'b0;
        end
      end
      if (i_push) begin
        r_mem[r_wrPtr] <= i_pushEntry;
        r_wrPtr        <= r_wrPtr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_count = r_count;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between the writeback stage and the
// MDU. Writeback passes straight through; MDU results wait in a small queue
// and drain into idle slots, with a forced pipeline stall if the head ages out.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int ADDR_Nbits = RF_ADDR_W,
  parameter int DATA_W     = RF_DATA_W,
  parameter int QDEPTH     = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic                        RegWrArb_CLK,
  input  logic                        RegWrArb_RST,
  input  logic                        RegWrArb_WB_WE,
  input  logic [ADDR_Nbits-1:0]       RegWrArb_WB_A3,
  input  logic [DATA_W-1:0]           RegWrArb_WB_WD,
  input  logic                        RegWrArb_MD_VALID,
  input  logic [ADDR_Nbits-1:0]       RegWrArb_MD_A3,
  input  logic [DATA_W-1:0]           RegWrArb_MD_WD,
  output logic                        RegWrArb_MD_READY,
  output logic                        RegWrArb_STALL,
  output logic [ADDR_Nbits-1:0]       RegWrArb_A3,
  output logic [DATA_W-1:0]           RegWrArb_WD3,
  output logic                        RegWrArb_WE3,
  output logic [$clog2(QDEPTH):0]     RegWrArb_PEND
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  arb_state_t       r_state;
  logic [AGE_W-1:0] r_age;
  logic             r_stall;
  logic             r_mdReady;

  q_entry_t         w_head;
  q_entry_t         w_pushEntry;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_nextCount;
  logic [1:0]       w_gnt;
  logic             w_wbReq;
  logic             w_hasHead;
  logic             w_headValid;
  logic             w_headInval;
  logic             w_push;
  logic             w_pop;

  // A WB write to r0 is a no-op and a stalled pipeline cannot write back.
  assign w_wbReq     = RegWrArb_WB_WE && !r_stall && !RegWrArb_RST
                       && (RegWrArb_WB_A3 != '0);
  assign w_hasHead   = (w_count != '0);
  assign w_headValid = w_hasHead && w_head.valid;
  assign w_headInval = w_wbReq && w_headValid && (w_head.a3 == RegWrArb_WB_A3);
  // The MDU result is older than a same-cycle WB to the same register, so it
  // is dropped instead of enqueued; r0 results are dropped too.
  assign w_push      = RegWrArb_MD_VALID && r_mdReady && !RegWrArb_RST
                       && (RegWrArb_MD_A3 != '0)
                       && !(w_wbReq && (RegWrArb_MD_A3 == RegWrArb_WB_A3));
  assign w_pushEntry = '{valid: 1'b1, a3: RegWrArb_MD_A3, wd: RegWrArb_MD_WD};
  assign w_nextCount = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

  regwr_queue #(
    .QDEPTH     (QDEPTH),
    .ADDR_Nbits (ADDR_Nbits),
    .CNT_W      (CNT_W)
  ) u_queue (
    .i_clk       (RegWrArb_CLK),
    .i_rst       (RegWrArb_RST),
    .i_push      (w_push),
    .i_pushEntry (w_pushEntry),
    .i_pop       (w_pop),
    .i_invEn     (w_wbReq),
    .i_invAddr   (RegWrArb_WB_A3),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  // Pick the port owner and drive the register file; stale heads pop silently.
  always_comb begin
    w_gnt        = GNT_NONE;
    w_pop        = 1'b0;
    RegWrArb_WE3 = 1'b0;
    RegWrArb_A3  = '0;
    RegWrArb_WD3 = '0;
    if (!RegWrArb_RST) begin
      if (r_stall) begin
        w_gnt = w_hasHead ? GNT_Q : GNT_NONE;
      end else if (w_wbReq) begin
        w_gnt = GNT_WB;
      end else if (w_hasHead) begin
        w_gnt = GNT_Q;
      end
      w_pop = w_hasHead && (!w_head.valid || (w_gnt == GNT_Q));
      if (w_gnt == GNT_WB) begin
        RegWrArb_WE3 = 1'b1;
        RegWrArb_A3  = RegWrArb_WB_A3;
        RegWrArb_WD3 = RegWrArb_WB_WD;
      end else if ((w_gnt == GNT_Q) && w_headValid) begin
        RegWrArb_WE3 = 1'b1;
        RegWrArb_A3  = w_head.a3;
        RegWrArb_WD3 = w_head.wd;
      end
    end
  end

  // Count how long a valid head has been passed over, saturating at the limit.
  always_ff @(posedge RegWrArb_CLK) begin
    if (RegWrArb_RST || w_pop || w_headInval) begin
      r_age <= '0;
    end else if (w_headValid && (w_gnt != GNT_Q) && (r_age != AGE_MAX)) begin
      r_age <= r_age + AGE_W'(1);
    end
  end

  // Track queue state and raise STALL for the single forced-drain cycle; an
  // aged head that pops anyway this cycle does not force a stall.
  always_ff @(posedge RegWrArb_CLK) begin
    if (RegWrArb_RST) begin
      r_state <= IDLE;
      r_stall <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_push) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if ((r_age == AGE_MAX) && !w_pop) begin
            r_state <= FORCE;
            r_stall <= 1'b1;
          end else if (w_nextCount == '0) begin
            r_state <= IDLE;
          end
        end
        FORCE: begin
          r_stall <= 1'b0;
          r_state <= (w_nextCount == '0) ? IDLE : WAIT;
        end
        default: begin
          r_state <= IDLE;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  // Advertise room for next cycle's MDU result from the post-edge occupancy.
  always_ff @(posedge RegWrArb_CLK) begin
    if (RegWrArb_RST) begin
      r_mdReady <= 1'b0;
    end else begin
      r_mdReady <= (w_nextCount < CNT_W'(QDEPTH));
    end
  end

  assign RegWrArb_MD_READY = r_mdReady;
  assign RegWrArb_STALL    = r_stall;
  assign RegWrArb_PEND     = w_count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: per-cycle expected write-port values
// go into a scoreboard queue and are compared at the falling edge; each
// scenario task also checks STALL, MD_READY and PEND inline.
module tb_regfile_write_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int QD = 2;
  localparam int MW = 4;
  localparam int PW = $clog2(QD) + 1;

  typedef struct {
    logic          we;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wbWe;
  logic [AW-1:0] wbA3;
  logic [DW-1:0] wbWd;
  logic          mdValid;
  logic [AW-1:0] mdA3;
  logic [DW-1:0] mdWd;
  logic          mdReady;
  logic          stall;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;
  logic          we3;
  logic [PW-1:0] pend;

  exp_t expQ[$];
  exp_t monE;
  int   checks = 0;
  int   errors = 0;

  regfile_write_arbiter #(
    .ADDR_Nbits (AW),
    .DATA_W     (DW),
    .QDEPTH     (QD),
    .MAX_WAIT   (MW)
  ) dut (
    .RegWrArb_CLK      (clk),
    .RegWrArb_RST      (rst),
    .RegWrArb_WB_WE    (wbWe),
    .RegWrArb_WB_A3    (wbA3),
    .RegWrArb_WB_WD    (wbWd),
    .RegWrArb_MD_VALID (mdValid),
    .RegWrArb_MD_A3    (mdA3),
    .RegWrArb_MD_WD    (mdWd),
    .RegWrArb_MD_READY (mdReady),
    .RegWrArb_STALL    (stall),
    .RegWrArb_A3       (a3),
    .RegWrArb_WD3      (wd3),
    .RegWrArb_WE3      (we3),
    .RegWrArb_PEND     (pend)
  );

  always #5 clk = ~clk;

  // Scoreboard: every sampled cycle with a queued expectation is compared.
  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      monE = expQ.pop_front();
      checks++;
      if (we3 !== monE.we || a3 !== monE.a3 || wd3 !== monE.wd) begin
        errors++;
        $display("[TB] FAIL write_port got WE3=%0b A3=%0d WD3=%h expected WE3=%0b A3=%0d WD3=%h",
                 we3, a3, wd3, monE.we, monE.a3, monE.wd);
      end
    end
  end

  // Drive one cycle after the rising edge, queue its expected port value,
  // then return at the falling edge where outputs are sampled.
  task automatic applyStimulus(input logic r,
                               input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wdat,
                               input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] mdat,
                               input logic eWe, input logic [AW-1:0] eA, input logic [DW-1:0] eD);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; wbWe = w; wbA3 = wa; wbWd = wdat;
    mdValid = mv; mdA3 = ma; mdWd = mdat;
    e.we = eWe; e.a3 = eA; e.wd = eD;
    expQ.push_back(e);
    @(negedge clk);
  endtask

  task automatic test_reset();
    applyStimulus(1, 1, 5, 32'h55, 1, 6, 32'h66, 0, 0, 0);
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %0b expected 0", stall); end
    checks++; if (mdReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %0b expected 0", mdReady); end
    checks++; if (pend !== 0) begin errors++; $display("[TB] FAIL reset_pend got %0d expected 0", pend); end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (mdReady !== 1'b0) begin errors++; $display("[TB] FAIL release_ready_early got %0b expected 0", mdReady); end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (mdReady !== 1'b1) begin errors++; $display("[TB] FAIL release_ready got %0b expected 1", mdReady); end
  endtask

  task automatic test_md_write();
    applyStimulus(0, 0, 0, 0, 1, 5, 32'h1234, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h1234);
    checks++; if (pend !== 1) begin errors++; $display("[TB] FAIL md_pend_one got %0d expected 1", pend); end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (pend !== 0) begin errors++; $display("[TB] FAIL md_pend_zero got %0d expected 0", pend); end
    checks++; if (mdReady !== 1'b1) begin errors++; $display("[TB] FAIL md_ready got %0b expected 1", mdReady); end
  endtask

  task automatic test_force();
    applyStimulus(0, 1, 1, 32'h100, 1, 7, 32'h7777, 1, 1, 32'h100);
    for (int i = 1; i <= MW + 1; i++) begin
      applyStimulus(0, 1, AW'(10 + i), 32'h200 + i, 0, 0, 0, 1, AW'(10 + i), 32'h200 + i);
      checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL force_early_stall cycle %0d got %0b expected 0", i, stall); end
      checks++; if (pend !== 1) begin errors++; $display("[TB] FAIL force_pend cycle %0d got %0d expected 1", i, pend); end
    end
    applyStimulus(0, 1, 7, 32'hDEAD, 0, 0, 0, 1, 7, 32'h7777);
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL force_stall got %0b expected 1", stall); end
    applyStimulus(0, 1, 2, 32'h300, 0, 0, 0, 1, 2, 32'h300);
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL force_release got %0b expected 0", stall); end
    checks++; if (pend !== 0) begin errors++; $display("[TB] FAIL force_pend_after got %0d expected 0", pend); end
  endtask

  task automatic test_cancel_full();
    applyStimulus(0, 1, 1, 32'h11, 1, 3, 32'h3333, 1, 1, 32'h11);
    applyStimulus(0, 1, 2, 32'h22, 1, 9, 32'h9999, 1, 2, 32'h22);
    checks++; if (mdReady !== 1'b1) begin errors++; $display("[TB] FAIL cancel_ready_one got %0b expected 1", mdReady); end
    applyStimulus(0, 1, 3, 32'hAAAA, 0, 0, 0, 1, 3, 32'hAAAA);
    checks++; if (mdReady !== 1'b0) begin errors++; $display("[TB] FAIL cancel_ready_full got %0b expected 0", mdReady); end
    checks++; if (pend !== 2) begin errors++; $display("[TB] FAIL cancel_pend_full got %0d expected 2", pend); end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (pend !== 2) begin errors++; $display("[TB] FAIL cancel_pend_stale got %0d expected 2", pend); end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h9999);
    checks++; if (pend !== 1) begin errors++; $display("[TB] FAIL cancel_pend_one got %0d expected 1", pend); end
    checks++; if (mdReady !== 1'b1) begin errors++; $display("[TB] FAIL cancel_ready_back got %0b expected 1", mdReady); end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (pend !== 0) begin errors++; $display("[TB] FAIL cancel_pend_empty got %0d expected 0", pend); end
  endtask

  task automatic test_same_cycle();
    applyStimulus(0, 1, 4, 32'h4444, 1, 4, 32'h5555, 1, 4, 32'h4444);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (pend !== 0) begin errors++; $display("[TB] FAIL same_cycle_pend got %0d expected 0", pend); end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_r0();
    applyStimulus(0, 1, 0, 32'hBAD, 1, 0, 32'hBAD2, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (pend !== 0) begin errors++; $display("[TB] FAIL r0_pend got %0d expected 0", pend); end
  endtask

  task automatic test_back_to_back();
    applyStimulus(0, 0, 0, 0, 1, 5, 32'hA, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 6, 32'hB, 1, 5, 32'hA);
    checks++; if (pend !== 1) begin errors++; $display("[TB] FAIL b2b_pend_first got %0d expected 1", pend); end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 6, 32'hB);
    checks++; if (pend !== 1) begin errors++; $display("[TB] FAIL b2b_pend_second got %0d expected 1", pend); end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (pend !== 0) begin errors++; $display("[TB] FAIL b2b_pend_empty got %0d expected 0", pend); end
  endtask

  task automatic test_reset_force();
    applyStimulus(0, 1, 1, 32'h1, 1, 3, 32'h3, 1, 1, 32'h1);
    applyStimulus(0, 1, 2, 32'h2, 1, 9, 32'h9, 1, 2, 32'h2);
    for (int i = 0; i < MW; i++) begin
      applyStimulus(0, 1, AW'(11 + i), 32'h500 + i, 0, 0, 0, 1, AW'(11 + i), 32'h500 + i);
      checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL rstf_early_stall cycle %0d got %0b expected 0", i, stall); end
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL rstf_stall got %0b expected 1", stall); end
    checks++; if (pend !== 2) begin errors++; $display("[TB] FAIL rstf_pend_full got %0d expected 2", pend); end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL rstf_stall_cleared got %0b expected 0", stall); end
    checks++; if (pend !== 0) begin errors++; $display("[TB] FAIL rstf_pend_cleared got %0d expected 0", pend); end
    checks++; if (mdReady !== 1'b0) begin errors++; $display("[TB] FAIL rstf_ready_low got %0b expected 0", mdReady); end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (mdReady !== 1'b1) begin errors++; $display("[TB] FAIL rstf_ready_high got %0b expected 1", mdReady); end
  endtask

  // Bound the whole run in case a scenario stops advancing.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; wbWe = 1'b0; wbA3 = '0; wbWd = '0;
    mdValid = 1'b0; mdA3 = '0; mdWd = '0;
    test_reset();
    test_md_write();
    test_force();
    test_cancel_full();
    test_same_cycle();
    test_r0();
    test_back_to_back();
    test_reset_force();
    @(posedge clk);
    checks++;
    if (expQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d entries expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
